// File: rtl/fetch_instr_queue_pkg.sv
// Shared types and JAL helpers for the fetch-to-decode instruction queue.
// The entry layout matches the default WIDTH=31 / INDEX=7 configuration.
package fetch_pkg;

  localparam int FQ_WIDTH = 31;
  localparam int FQ_INDEX = 7;

  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef struct packed {
    logic [FQ_WIDTH:0] instr;
    logic [FQ_WIDTH:0] pc;
    logic [FQ_WIDTH:0] predPC;
    logic [FQ_INDEX:0] index;
    logic [1:0]        state;
    logic              redirect;
  } fetchEntry_t;

  // Sign-extended J-type immediate; bit 0 is always zero.
  function automatic logic [31:0] jalImm(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_instr_queue_if.sv
// Fetch-side and decode-side signals of the instruction queue.
// slave is the queue itself; master is whatever drives fetch and decode.
interface fetch_instr_queue_if #(
  parameter int WIDTH = 31,
  parameter int INDEX = 7,
  parameter int DEPTH = 8
);

  logic                   flush;
  logic                   fetchValid;
  logic [WIDTH:0]         instr;
  logic [WIDTH:0]         instrPC;
  logic [WIDTH:0]         predictedPCF;
  logic [INDEX:0]         GHRIndex;
  logic [1:0]             PHTState;
  logic                   redirect;
  logic                   freeze;
  logic                   isJAL;
  logic [WIDTH:0]         validAddress;
  logic                   deqReady;
  logic                   deqValid;
  logic [WIDTH:0]         dInstr;
  logic [WIDTH:0]         dPC;
  logic [WIDTH:0]         dPredPC;
  logic [INDEX:0]         dIndex;
  logic [1:0]             dState;
  logic                   dRedirect;
  logic [$clog2(DEPTH):0] count;

  modport slave (
    input  flush, fetchValid, instr, instrPC, predictedPCF, GHRIndex, PHTState,
           redirect, deqReady,
    output freeze, isJAL, validAddress, deqValid, dInstr, dPC, dPredPC, dIndex,
           dState, dRedirect, count
  );

  modport master (
    output flush, fetchValid, instr, instrPC, predictedPCF, GHRIndex, PHTState,
           redirect, deqReady,
    input  freeze, isJAL, validAddress, deqValid, dInstr, dPC, dPredPC, dIndex,
           dState, dRedirect, count
  );

endinterface

// File: rtl/fetch_instr_queue_jal_predecode.sv
// Combinational JAL predecode on the bundle entering the queue.
// jal flags a JAL whose target the BTB did not already predict.
module jal_predecode
  import fetch_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] predPC,
  input  logic        redirect,
  output logic        jal,
  output logic [31:0] target
);

  logic is_jal_s;
  logic btb_hit_s;
  logic unused_rd_s;

  assign unused_rd_s = ^instr[11:7];

  // Target wraps modulo 2^32; a correct BTB redirect suppresses the steer.
  always_comb begin
    is_jal_s  = (instr[6:0] == OP_JAL);
    target    = pc + jalImm(instr);
    btb_hit_s = redirect & (predPC == target);
    jal       = is_jal_s & ~btb_hit_s;
  end

endmodule

// File: rtl/fetch_instr_queue.sv
// Circular fetch queue between fetch and decode with JAL steering on enqueue.
// Occupancy is tracked by a separate counter so a full queue is unambiguous.
module fetch_instr_queue
  import fetch_pkg::*;
#(
  parameter int WIDTH = FQ_WIDTH,
  parameter int INDEX = FQ_INDEX,
  parameter int DEPTH = 8
) (
  input logic                clk,
  input logic                globalReset,
  fetch_instr_queue_if.slave q
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [PW-1:0] ONE_P  = PW'(1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  fetchEntry_t    mem_r [DEPTH];
  logic [PW-1:0]  head_r;
  logic [PW-1:0]  tail_r;
  logic [CW-1:0]  count_r;

  logic           deq_valid_s;
  logic           enq_s;
  logic           deq_s;
  logic           jal_s;
  logic [WIDTH:0] target_s;
  fetchEntry_t    wr_s;
  fetchEntry_t    head_s;

  jal_predecode u_predecode (
    .instr    (q.instr),
    .pc       (q.instrPC),
    .predPC   (q.predictedPCF),
    .redirect (q.redirect),
    .jal      (jal_s),
    .target   (target_s)
  );

  // Handshake: a full queue still accepts when the head leaves the same cycle.
  always_comb begin
    deq_valid_s = (count_r != '0);
    deq_s       = deq_valid_s & q.deqReady & ~q.flush;
    enq_s       = q.fetchValid & ~q.flush & ((count_r != FULL_C) | deq_s);
    wr_s        = '{instr:    q.instr,
                    pc:       q.instrPC,
                    predPC:   q.predictedPCF,
                    index:    q.GHRIndex,
                    state:    q.PHTState,
                    redirect: q.redirect};
    if (deq_valid_s) begin
      head_s = mem_r[head_r];
    end else begin
      head_s = '0;
    end
  end

  assign q.freeze       = q.fetchValid & ~enq_s & ~q.flush;
  assign q.isJAL        = enq_s & jal_s;
  assign q.validAddress = target_s;
  assign q.deqValid     = deq_valid_s;
  assign q.dInstr       = head_s.instr;
  assign q.dPC          = head_s.pc;
  assign q.dPredPC      = head_s.predPC;
  assign q.dIndex       = head_s.index;
  assign q.dState       = head_s.state;
  assign q.dRedirect    = head_s.redirect;
  assign q.count        = count_r;

  // Entry storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (globalReset && enq_s) begin
      mem_r[tail_r] <= wr_s;
    end
  end

  // Pointers and occupancy; reset beats flush, flush beats enqueue/dequeue.
  always_ff @(posedge clk) begin
    if (!globalReset) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (q.flush) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq_s) begin
        tail_r <= tail_r + ONE_P;
      end else begin
        tail_r <= tail_r;
      end
      if (deq_s) begin
        head_r <= head_r + ONE_P;
      end else begin
        head_r <= head_r;
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + ONE_C;
        2'b01:   count_r <= count_r - ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_instr_queue.sv
// Directed bench for fetch_instr_queue with a scoreboard of queued bundles.
module tb_fetch_instr_queue;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] JALP = 32'h0100_006F;
  localparam logic [31:0] JALN = 32'hFF9F_F06F;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pred;
    logic [7:0]  idx;
    logic [1:0]  st;
    logic        red;
  } exp_t;

  logic clk = 1'b0;
  logic globalReset;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  fetch_instr_queue_if #(.WIDTH(31), .INDEX(7), .DEPTH(8)) bus ();

  fetch_instr_queue #(.WIDTH(31), .INDEX(7), .DEPTH(8)) dut (
    .clk         (clk),
    .globalReset (globalReset),
    .q           (bus)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_target(input logic [31:0] ins, input logic [31:0] pc);
    logic [20:0] off;
    off = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    return pc + {{11{off[20]}}, off};
  endfunction

  task automatic drive(input logic fv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic red, input logic [31:0] pred, input logic rdy,
                       input logic fl);
    bus.fetchValid   = fv;
    bus.instr        = ins;
    bus.instrPC      = pc;
    bus.redirect     = red;
    bus.predictedPCF = pred;
    bus.GHRIndex     = pc[9:2];
    bus.PHTState     = pc[3:2];
    bus.deqReady     = rdy;
    bus.flush        = fl;
  endtask

  // Checks the combinational view against the model, then advances one edge.
  task automatic cycle(input string tag);
    int          n;
    logic        e_deq, e_enq, e_jal, fl, rst;
    logic [31:0] tgt;
    exp_t        e;
    logic [127:0] head_exp;
    #2;
    n     = sb.size();
    fl    = bus.flush;
    rst   = globalReset;
    tgt   = ref_target(bus.instr, bus.instrPC);
    e_deq = (n != 0) && bus.deqReady && !fl;
    e_enq = bus.fetchValid && !fl && ((n < 8) || e_deq);
    e_jal = e_enq && (bus.instr[6:0] == 7'h6F) && !(bus.redirect && (bus.predictedPCF == tgt));
    head_exp = '0;
    if (n != 0) head_exp = {sb[0].instr, sb[0].pc, sb[0].pred, sb[0].idx, sb[0].st, sb[0].red};
    chk({tag, ".count"}, bus.count, n);
    chk({tag, ".deqValid"}, bus.deqValid, (n != 0));
    chk({tag, ".head"}, {bus.dInstr, bus.dPC, bus.dPredPC, bus.dIndex, bus.dState, bus.dRedirect},
        head_exp);
    chk({tag, ".freeze"}, bus.freeze, bus.fetchValid && !e_enq && !fl);
    chk({tag, ".isJAL"}, bus.isJAL, e_jal);
    if (e_jal) chk({tag, ".validAddress"}, bus.validAddress, tgt);
    e = '{bus.instr, bus.instrPC, bus.predictedPCF, bus.GHRIndex, bus.PHTState, bus.redirect};
    @(posedge clk);
    if (!rst || fl) begin
      sb.delete();
    end else begin
      if (e_deq) void'(sb.pop_front());
      if (e_enq) sb.push_back(e);
    end
    #1;
  endtask

  initial begin
    // Reset
    globalReset = 1'b0;
    drive(1'b0, NOP, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    cycle("rst");
    globalReset = 1'b1;

    // Three enqueues with decode stalled
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, NOP, 32'(i * 4), 1'b0, 32'(i * 4 + 4), 1'b0, 1'b0);
      #1;
      chk("tp1.freeze", bus.freeze, 1'b0);
      cycle("fill3");
    end
    drive(1'b0, NOP, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("tp1.count", bus.count, 4'd3);
    chk("tp1.dPC", bus.dPC, 32'h0);
    cycle("idle");

    // Fill to 8, then a JAL arrives while full
    for (int i = 3; i < 8; i++) begin
      drive(1'b1, NOP, 32'(i * 4), 1'b0, 32'(i * 4 + 4), 1'b0, 1'b0);
      cycle("fill8");
    end
    drive(1'b1, JALP, 32'h20, 1'b0, 32'h24, 1'b0, 1'b0);
    #1;
    chk("full.freeze", bus.freeze, 1'b1);
    chk("full.count", bus.count, 4'd8);
    chk("full.isJAL", bus.isJAL, 1'b0);
    cycle("full");
    drive(1'b1, JALP, 32'h20, 1'b0, 32'h24, 1'b1, 1'b0);
    #1;
    chk("enqdeq.freeze", bus.freeze, 1'b0);
    chk("enqdeq.isJAL", bus.isJAL, 1'b1);
    chk("enqdeq.validAddress", bus.validAddress, 32'h30);
    cycle("enqdeq");
    chk("enqdeq.count", bus.count, 4'd8);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, NOP, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      cycle("drain8");
    end

    // JAL predecode cases
    drive(1'b1, JALP, 32'h100, 1'b0, 32'h104, 1'b0, 1'b0);
    #1;
    chk("jal.isJAL", bus.isJAL, 1'b1);
    chk("jal.validAddress", bus.validAddress, 32'h110);
    cycle("jal");
    drive(1'b1, JALP, 32'h100, 1'b1, 32'h110, 1'b0, 1'b0);
    #1;
    chk("jalhit.isJAL", bus.isJAL, 1'b0);
    cycle("jalhit");
    drive(1'b1, JALP, 32'h200, 1'b1, 32'h204, 1'b0, 1'b0);
    #1;
    chk("jalmiss.isJAL", bus.isJAL, 1'b1);
    chk("jalmiss.validAddress", bus.validAddress, 32'h210);
    cycle("jalmiss");
    drive(1'b1, JALN, 32'h4, 1'b0, 32'h8, 1'b0, 1'b0);
    #1;
    chk("jalneg.isJAL", bus.isJAL, 1'b1);
    chk("jalneg.validAddress", bus.validAddress, 32'hFFFF_FFFC);
    cycle("jalneg");
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, NOP, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      cycle("drain4");
    end

    // Flush with five entries queued and a JAL presented
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, NOP, 32'(32'h400 + i * 4), 1'b0, 32'h0, 1'b0, 1'b0);
      cycle("fill5");
    end
    drive(1'b1, JALP, 32'h300, 1'b0, 32'h0, 1'b1, 1'b1);
    #1;
    chk("flush.isJAL", bus.isJAL, 1'b0);
    chk("flush.freeze", bus.freeze, 1'b0);
    cycle("flush");
    drive(1'b0, NOP, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("postflush.count", bus.count, 4'd0);
    chk("postflush.deqValid", bus.deqValid, 1'b0);
    cycle("postflush");

    // Reset in the middle of a fill
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, NOP, 32'(32'h500 + i * 4), 1'b0, 32'h0, 1'b0, 1'b0);
      cycle("fillr");
    end
    globalReset = 1'b0;
    drive(1'b0, NOP, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle("midrst");
    chk("midrst.count", bus.count, 4'd0);
    chk("midrst.deqValid", bus.deqValid, 1'b0);
    chk("midrst.d", {bus.dInstr, bus.dPC, bus.dPredPC, bus.dIndex, bus.dState, bus.dRedirect},
        128'h0);
    chk("midrst.isJAL", bus.isJAL, 1'b0);
    globalReset = 1'b1;
    drive(1'b1, NOP, 32'h600, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle("after");
    drive(1'b0, NOP, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle("last");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
